scan_chain_driver: RTL and testbench
====================================

# scan_chain_driver

Test-mode controller that drives the scan inputs (SCE, SCD) of a chain of scan flip-flops and the GATE input of the chain's clock-gating cell. It serially loads a parallel stimulus pattern, issues one functional capture clock, then unloads the captured response as a parallel word. It sits directly upstream of the scan-flop chain and consumes that chain's scan-out bit.

## Interface
- CHAIN_LEN, 32, number of flops in the chain (≥2)
- CNT_W, $clog2(CHAIN_LEN+1), localparam, bit-counter width
- CLK  in  1  clock; also the ungated source of the chain's clock-gating cell
- RESET_B  in  1  reset, asynchronous, active-low
- start_valid  in  1  request to run one load/capture/unload sequence
- start_ready  out  1  high only in IDLE
- pattern  in  CHAIN_LEN  stimulus, sampled on start handshake; bit i lands in chain position i
- resp_valid  out  1  response available (DONE state)
- resp_ready  in  1  consumer accepts response
- resp  out  CHAIN_LEN  captured chain contents; bit i = chain position i
- scan_se  out  1  to every flop's SCE
- scan_si  out  1  to SCD of chain position 0
- scan_so  in  1  Q of chain position CHAIN_LEN-1
- chain_clk_en  out  1  to GATE of the chain's latch-based clock gate

## Operation
- Chain position 0 is fed by scan_si; position CHAIN_LEN-1 drives scan_so.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: latch pattern into shift register and load the bit counter with CHAIN_LEN. Next state SHIFT_IN.
- SHIFT_IN: CHAIN_LEN cycles.
  - scan_se=1, chain_clk_en=1.
  - scan_si presents pattern[CHAIN_LEN-1] first, then downward to pattern[0].
  - scan_so is ignored.
  - Counter reaches 0 → CAPTURE.
- CAPTURE: 1 cycle.
  - scan_se=0, chain_clk_en=1; the chain clocks its functional D inputs.
  - Next state SHIFT_OUT; counter reloads with CHAIN_LEN.
- SHIFT_OUT: CHAIN_LEN cycles.
  - scan_se=1, scan_si=0, chain_clk_en=1.
  - On each CLK rise, scan_so is sampled (the pre-shift value) into the response register: shift left, insert at LSB.
  - After CHAIN_LEN samples, resp[i] = captured value of position i. Next state DONE.
- DONE:
  - resp_valid=1; resp is stable; chain_clk_en=0; scan_se=0.
  - Remains in DONE until resp_ready → IDLE.
- start_valid outside IDLE is ignored; no queuing.
- resp_ready outside DONE is ignored.

## Timing
- All outputs are registered from CLK.
- Reset values: start_ready=1 (IDLE), resp_valid=0, resp=0, scan_se=0, scan_si=0, chain_clk_en=0.
- Control values that change after CLK edge k are acted on by the chain at edge k+1. The gating latch is transparent while CLK is low.
- Start accepted at edge E0:
  - shift edges E1..E_N;
  - capture edge E_{N+1};
  - unload edges E_{N+2}..E_{2N+1};
  - resp_valid high after E_{2N+1}.
- Latency from start accept to resp_valid is 2N+1 cycles (N = CHAIN_LEN).
- If resp_ready is already high in DONE's first cycle, the block returns to IDLE one cycle later, so start_ready is high after E_{2N+2}.
- Back-to-back operation: minimum 2N+3 cycles per sequence.
- RESET_B asserted mid-sequence forces all outputs to their reset values immediately. Chain contents are then undefined; no partial response is produced.

## Configuration
- SCAN_COMPARE_EN defined:
  - Adds inputs expect and mask (each CHAIN_LEN wide, latched with pattern).
  - Adds output mismatch: registered, valid with resp_valid, equal to |((resp ^ expect) & mask).
  - Adds output err_cnt: 16 bits, saturating, incremented on each resp handshake with mismatch=1, cleared only by reset.
- SCAN_COMPARE_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Package scan_drv_pkg holds:
  - the state enum typedef (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE);
  - ERR_CNT_W = 16.
- One sub-module, scan_drv_sreg: the CHAIN_LEN-bit parallel-load/serial-out stimulus register plus serial-in/parallel-out response register, with load/shift enables.
- FSM and bit counter live in the top module.

## Test plan
All scenarios use CHAIN_LEN=8. The bench chain is 8 scan flops with each functional D = ~Q, clocked through a latch clock gate.
- Reset then idle 5 cycles → scan_se=0, chain_clk_en=0, start_ready=1, resp_valid=0, resp=0.
- pattern=8'hA5, start pulse → scan_si sequence 1,0,1,0,0,1,0,1; resp=8'h5A with resp_valid exactly 17 cycles after accept.
- pattern=8'hFF with resp_ready held low for 10 cycles → resp stays 8'h00, resp_valid stays high, start_ready=0, chain_clk_en=0 throughout; 1 cycle after resp_ready rises, state is IDLE.
- start_valid held high continuously with resp_ready=1 → new sequence every 19 cycles; second start_valid during SHIFT_OUT is ignored.
- RESET_B pulsed low at cycle 6 of SHIFT_IN → outputs return to reset values in the same cycle; the next start with 8'h3C yields resp=8'hC3.
- SCAN_COMPARE_EN: pattern=8'h0F, expect=8'hF0, mask=8'hFF → mismatch=0. Then expect=8'hF1, mask=8'hFF → mismatch=1, err_cnt=1. Same expect with mask=8'hFE → mismatch=0, err_cnt unchanged.

Source files
------------

// File: rtl/scan_drv_pkg.sv
// scan_drv_pkg: shared state encoding and widths for the scan chain driver
package scan_drv_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
    localparam int ERR_CNT_W = 16;
endpackage

// File: rtl/scan_drv_sreg.sv
// scan_drv_sreg: parallel-load/serial-out stimulus register and serial-in/parallel-out response register
module scan_drv_sreg #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RESET_B,
    input  logic         i_load,
    input  logic         i_shift_in,
    input  logic         i_shift_out,
    input  logic         i_so,
    input  logic [N-1:0] i_pattern,
    output logic         o_si,
    output logic [N-1:0] o_resp
);
    logic [N-1:0] r_stim;
    logic [N-1:0] r_resp;
    // zero fill means scan_si is already 0 once the stimulus has fully left
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_stim <= '0;
            r_resp <= '0;
        end else begin
            if (i_load) r_stim <= i_pattern;
            else if (i_shift_in) r_stim <= {r_stim[N-2:0], 1'b0};
            if (i_shift_out) r_resp <= {r_resp[N-2:0], i_so};
        end
    end
    assign o_si   = r_stim[N-1];
    assign o_resp = r_resp;
endmodule

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: load / capture / unload sequencer for a scan-flop chain and its clock gate
// Optional response comparison and error counter enabled by SCAN_COMPARE_EN.
module scan_chain_driver
    import scan_drv_pkg::*;
#(
    parameter int CHAIN_LEN = 32
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic                 i_start_valid,
    output logic                 o_start_ready,
    input  logic [CHAIN_LEN-1:0] i_pattern,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic [CHAIN_LEN-1:0] o_resp,
    output logic                 o_scan_se,
    output logic                 o_scan_si,
    input  logic                 i_scan_so,
`ifdef SCAN_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] i_expect,
    input  logic [CHAIN_LEN-1:0] i_mask,
    output logic                 o_mismatch,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
`endif
    output logic                 o_chain_clk_en
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start_ready, r_resp_valid, r_scan_se, r_chain_clk_en;
    logic             w_accept, w_cnt_last;
    assign w_accept   = (r_state == IDLE) && i_start_valid;
    assign w_cnt_last = r_cnt == CNT_W'(1);
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      w_state_nxt = i_start_valid ? SHIFT_IN : IDLE;
            SHIFT_IN:  w_state_nxt = w_cnt_last ? CAPTURE : SHIFT_IN;
            CAPTURE:   w_state_nxt = SHIFT_OUT;
            SHIFT_OUT: w_state_nxt = w_cnt_last ? DONE : SHIFT_OUT;
            DONE:      w_state_nxt = i_resp_ready ? IDLE : DONE;
            default:   w_state_nxt = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_start_ready  <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_scan_se      <= 1'b0;
            r_chain_clk_en <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= (w_accept || r_state == CAPTURE) ? CNT_W'(CHAIN_LEN) :
                              (r_state inside {SHIFT_IN, SHIFT_OUT}) ? r_cnt - CNT_W'(1) : r_cnt;
            r_start_ready  <= w_state_nxt == IDLE;
            r_resp_valid   <= w_state_nxt == DONE;
            r_scan_se      <= w_state_nxt inside {SHIFT_IN, SHIFT_OUT};
            r_chain_clk_en <= w_state_nxt inside {SHIFT_IN, CAPTURE, SHIFT_OUT};
        end
    end
    scan_drv_sreg #(.N(CHAIN_LEN)) u_sreg (
        .CLK        (CLK),
        .RESET_B    (RESET_B),
        .i_load     (w_accept),
        .i_shift_in (r_state == SHIFT_IN),
        .i_shift_out(r_state == SHIFT_OUT),
        .i_so       (i_scan_so),
        .i_pattern  (i_pattern),
        .o_si       (o_scan_si),
        .o_resp     (o_resp)
    );
    assign o_start_ready  = r_start_ready;
    assign o_resp_valid   = r_resp_valid;
    assign o_scan_se      = r_scan_se;
    assign o_chain_clk_en = r_chain_clk_en;
`ifdef SCAN_COMPARE_EN
    logic [CHAIN_LEN-1:0] r_expect, r_mask;
    logic [CHAIN_LEN-1:0] w_resp_fin;
    logic                 r_mismatch;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    // final response word as it will look after the last unload edge
    assign w_resp_fin = {o_resp[CHAIN_LEN-2:0], i_scan_so};
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_expect   <= '0;
            r_mask     <= '0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_expect <= i_expect;
                r_mask   <= i_mask;
            end
            if (r_state == SHIFT_OUT && w_cnt_last) r_mismatch <= |((w_resp_fin ^ r_expect) & r_mask);
            if (r_state == DONE && i_resp_ready && r_mismatch && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end
    assign o_mismatch = r_mismatch;
    assign o_err_cnt  = r_err_cnt;
`endif
endmodule

// File: tb/tb_scan_chain_driver.sv
// tb_scan_chain_driver: directed bench with an 8-flop D=~Q scan chain behind a latch clock gate
module tb_scan_chain_driver;
    logic       CLK = 1'b0;
    logic       RESET_B = 1'b0;
    logic       start_valid = 1'b0, resp_ready = 1'b0;
    logic [7:0] pattern = '0;
    logic       start_ready, resp_valid, scan_se, scan_si, chain_clk_en;
    logic [7:0] resp;
    logic [7:0] chain;
    logic       gate = 1'b0;
    logic       gclk;
    int         checks = 0, failures = 0;
`ifdef SCAN_COMPARE_EN
    logic [7:0]  expect_v = '0, mask = '0;
    logic        mismatch;
    logic [15:0] err_cnt;
`endif

    scan_chain_driver #(.CHAIN_LEN(8)) dut (
        .CLK           (CLK),
        .RESET_B       (RESET_B),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_pattern     (pattern),
        .o_resp_valid  (resp_valid),
        .i_resp_ready  (resp_ready),
        .o_resp        (resp),
        .o_scan_se     (scan_se),
        .o_scan_si     (scan_si),
        .i_scan_so     (chain[7]),
`ifdef SCAN_COMPARE_EN
        .i_expect      (expect_v),
        .i_mask        (mask),
        .o_mismatch    (mismatch),
        .o_err_cnt     (err_cnt),
`endif
        .o_chain_clk_en(chain_clk_en)
    );

    always #5 CLK = ~CLK;

    // gating latch transparent while CLK is low
    always @(CLK or chain_clk_en) if (!CLK) gate = chain_clk_en;
    assign gclk = CLK & gate;
    always @(posedge gclk) chain <= scan_se ? {chain[6:0], scan_si} : ~chain;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // accept at the next edge, then step to the cycle where resp_valid must first rise
    task automatic run_seq(input logic [7:0] p, input string tag);
        pattern = p;
        start_valid = 1'b1;
        cyc();
        start_valid = 1'b0;
        repeat (16) cyc();
        chk({tag, "_valid_early"}, resp_valid, 0);
        cyc();
        chk({tag, "_valid_17"}, resp_valid, 1);
    endtask

    initial begin
        logic [7:0] pa;
        repeat (3) cyc();
        RESET_B = 1'b1;
        repeat (5) cyc();
        chk("rst_outs", {scan_se, chain_clk_en, start_ready, resp_valid, scan_si}, 5'b00100);
        chk("rst_resp", resp, 8'h00);

        pa = 8'hA5;
        pattern = pa;
        start_valid = 1'b1;
        cyc();
        start_valid = 1'b0;
        chk("a5_shift_ctl", {scan_se, chain_clk_en, start_ready}, 3'b110);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("a5_si%0d", k), scan_si, pa[7-k]);
            cyc();
        end
        chk("a5_capture", {scan_se, chain_clk_en}, 2'b01);
        cyc();
        chk("a5_unload", {scan_se, chain_clk_en, scan_si}, 3'b110);
        repeat (7) cyc();
        chk("a5_valid_16", resp_valid, 0);
        cyc();
        chk("a5_valid_17", resp_valid, 1);
        chk("a5_resp", resp, 8'h5A);
        chk("a5_done_ctl", {scan_se, chain_clk_en, start_ready}, 3'b000);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("a5_idle", {start_ready, resp_valid}, 2'b10);

        run_seq(8'hFF, "ff");
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("ff_hold%0d", k), {resp, resp_valid, start_ready, chain_clk_en}, {8'h00, 3'b100});
            cyc();
        end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("ff_idle", {start_ready, resp_valid}, 2'b10);

        pattern = 8'h12;
        start_valid = 1'b1;
        resp_ready = 1'b1;
        cyc();
        pattern = 8'hC0;
        repeat (16) cyc();
        chk("b2b_valid_16", resp_valid, 0);
        cyc();
        chk("b2b_valid_17", resp_valid, 1);
        chk("b2b_resp1", resp, 8'hED);
        cyc();
        chk("b2b_idle_18", {start_ready, resp_valid}, 2'b10);
        cyc();
        chk("b2b_accept_19", {start_ready, scan_se}, 2'b01);
        repeat (16) cyc();
        chk("b2b_valid_35", resp_valid, 0);
        cyc();
        chk("b2b_valid_36", resp_valid, 1);
        chk("b2b_resp2", resp, 8'h3F);
        start_valid = 1'b0;
        cyc();
        chk("b2b_idle_end", {start_ready, resp_valid}, 2'b10);
        resp_ready = 1'b0;

        pattern = 8'h55;
        start_valid = 1'b1;
        cyc();
        start_valid = 1'b0;
        repeat (5) cyc();
        chk("mid_shifting", {scan_se, chain_clk_en}, 2'b11);
        RESET_B = 1'b0;
        #1;
        chk("mid_rst_outs", {scan_se, chain_clk_en, start_ready, resp_valid, scan_si}, 5'b00100);
        chk("mid_rst_resp", resp, 8'h00);
        cyc();
        RESET_B = 1'b1;
        cyc();
        run_seq(8'h3C, "c3");
        chk("c3_resp", resp, 8'hC3);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;

`ifdef SCAN_COMPARE_EN
        expect_v = 8'hF0;
        mask = 8'hFF;
        run_seq(8'h0F, "cmp0");
        chk("cmp0_resp", resp, 8'hF0);
        chk("cmp0_mismatch", mismatch, 0);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("cmp0_err_cnt", err_cnt, 0);
        expect_v = 8'hF1;
        run_seq(8'h0F, "cmp1");
        chk("cmp1_mismatch", mismatch, 1);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("cmp1_err_cnt", err_cnt, 1);
        mask = 8'hFE;
        run_seq(8'h0F, "cmp2");
        chk("cmp2_mismatch", mismatch, 0);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("cmp2_err_cnt", err_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
